nway_cache: RTL and testbench
=============================

# nway_cache

Parametrised N-way set-associative, write-back, write-allocate data cache with multi-word lines and true-LRU replacement. Sits between the core's load/store unit and main memory. Serves hits in the request cycle. On a miss it writes back a dirty victim and refills the line over a word-serial req/ack memory port, stalling the core through `cpu_ready`.

## Interface
- `DATA_WIDTH`, 32: word width; byte offset = log2(DATA_WIDTH/8) bits.
- `ADDR_WIDTH`, 32: byte-address width.
- `NUM_WAYS`, 2: associativity; power of two, 1..8.
- `NUM_SETS`, 8: sets; power of two, ≥2.
- `WORDS_PER_LINE`, 4: words per line; power of two, ≥1.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  access request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = write word, 0 = read.
- `cpu_addr`  in  ADDR_WIDTH  byte address; byte-offset bits ignored.
- `cpu_wdata`  in  DATA_WIDTH  write data.
- `cpu_rdata`  out  DATA_WIDTH  read data; valid when `cpu_ready` and `!cpu_we`.
- `cpu_ready`  out  1  access completes this cycle.
- `mem_req`  out  1  memory beat request.
- `mem_we`  out  1  beat is a write-back.
- `mem_addr`  out  ADDR_WIDTH  word-aligned beat address.
- `mem_wdata`  out  DATA_WIDTH  write-back data.
- `mem_rdata`  in  DATA_WIDTH  refill data; sampled when `mem_ack`.
- `mem_ack`  in  1  beat accepted/returned this cycle.

## Operation
- Address split, LSB first: byte offset, word offset (log2 WORDS_PER_LINE), set (log2 NUM_SETS), tag (remainder).
- Per set and way: valid bit, dirty bit, tag, WORDS_PER_LINE data words, age counter of max(1, log2 NUM_WAYS) bits.
- Hit: a valid way with a matching tag. At most one way can hit.
- FSM states: LOOKUP, WRITEBACK, REFILL.
- LOOKUP, hit: `cpu_ready`=1 combinationally. Read drives `cpu_rdata` from the hit word. Write updates that word and sets dirty at the edge. LRU is touched.
- LOOKUP, miss with `cpu_req`: latch the victim way and beat counter = 0. Go to WRITEBACK if the victim is valid and dirty, otherwise REFILL.
- Victim: lowest-index invalid way; if none, the way with age = NUM_WAYS-1.
- WRITEBACK: `mem_req`=1, `mem_we`=1. `mem_addr` = {victim tag, set, beat, 0}; `mem_wdata` = victim word[beat]. Each `mem_ack` advances the beat. After the last ack, clear dirty, reset beat, go to REFILL.
- REFILL: `mem_req`=1, `mem_we`=0. `mem_addr` = {request tag, set, beat, 0}. Each `mem_ack` writes `mem_rdata` into the victim word[beat]. After the last ack, write the tag, set valid, clear dirty, go to LOOKUP. The held request then hits (write-allocate completes there).
- LRU touch on way w: every way in the set with age < age[w] increments; age[w] ← 0.
- `mem_ack` is ignored while `mem_req`=0. `cpu_req` is ignored outside LOOKUP.
- The core must hold `cpu_req`/`cpu_addr`/`cpu_we`/`cpu_wdata` stable until `cpu_ready`. If `cpu_req` drops mid-miss, the fill still completes.
- NUM_WAYS=1: direct-mapped; the victim is always way 0.

## Timing
- Reset (async assert, sync deassert use): all valid/dirty = 0, age[w] = w, FSM = LOOKUP, beat = 0.
- Reset output values: `cpu_ready`=0, `cpu_rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset during WRITEBACK/REFILL abandons the transfer. Dirty data is lost and `mem_req` drops immediately.
- Hit latency: 0 cycles (ready in the request cycle).
- Clean-miss latency: 1 + WORDS_PER_LINE×(ack wait + 1) + 1 cycles. A dirty miss adds WORDS_PER_LINE beats.
- `mem_addr`, `mem_we`, `mem_wdata` stay stable while `mem_req`=1 and `mem_ack`=0.
- `mem_req` stays high between beats of the same phase and between WRITEBACK and REFILL. It drops in the cycle after the last refill ack.

## Structure
- `cache_pkg`: FSM state enum (`LOOKUP`, `WRITEBACK`, `REFILL`) and functions deriving offset/set/tag widths from the parameters.
- Sub-module `lru_tracker`: per-set age array, victim selection, touch and reset. Parametrised by NUM_WAYS and NUM_SETS.

## Test plan
Defaults, except where noted: set = addr[6:4], tag = addr[31:7].
- Cold read 0x040 → 4 read beats at 0x40, 0x44, 0x48, 0x4C, then `cpu_ready` with rdata = mem[0x40]. Read 0x044 next → ready the same cycle, `mem_req` stays 0.
- Write hit 0x044 = 0xDEADBEEF → ready the same cycle with no memory traffic. Read 0x044 returns 0xDEADBEEF.
- Set 4 conflicts:
  - Sequence: write 0x040, read 0x0C0, read 0x040, read 0x140.
  - 0x140 evicts 0x0C0 (clean), so no write-back.
  - Then read 0x0C0: it evicts dirty 0x040, giving write beats 0x40..0x4C (0x44 = 0xDEADBEEF) before the refill reads.
- `mem_ack` delayed 3 cycles per beat → `mem_addr`/`mem_wdata` stable during each wait. Miss latency = 1 + 4×4 + 1 = 18 cycles.
- `rst_n` low during refill beat 2 → `mem_req` = 0 immediately. Re-reading the same address misses and performs the full 4-beat refill.
- NUM_WAYS=4: fill set 0 with tags A, B, C, D, touch A, then access E → D... victim is B (the oldest). Then access F → victim is C.

Source files
------------

// File: rtl/nway_cache_pkg.sv
// Shared types and address-field width helpers for the N-way write-back cache.
package nway_cache_pkg;

    typedef enum logic [1:0] {
        LOOKUP,
        WRITEBACK,
        REFILL
    } cache_state_e;

    // Counters and way indices need at least one bit even when the count is 1.
    function automatic int unsigned min1_clog2(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned byte_off_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int unsigned word_off_bits(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    function automatic int unsigned set_bits(input int unsigned num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int unsigned tag_bits(input int unsigned addr_width,
                                             input int unsigned data_width,
                                             input int unsigned words_per_line,
                                             input int unsigned num_sets);
        return addr_width - byte_off_bits(data_width) - word_off_bits(words_per_line)
               - set_bits(num_sets);
    endfunction

endpackage

// File: rtl/nway_cache_if.sv
// CPU-side and memory-side signals of the cache; the cache uses the slave view.
interface nway_cache_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/nway_cache_lru_tracker.sv
// True-LRU age counters per set: victim selection and touch on hit.
module lru_tracker
    import nway_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 2,
    parameter int unsigned NUM_SETS = 8,
    localparam int unsigned WAY_BITS = min1_clog2(NUM_WAYS),
    localparam int unsigned SET_BITS = set_bits(NUM_SETS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SET_BITS-1:0] lookup_set,
    input  logic [NUM_WAYS-1:0] set_valid,
    output logic [WAY_BITS-1:0] victim_way,
    input  logic                touch_en,
    input  logic [SET_BITS-1:0] touch_set,
    input  logic [WAY_BITS-1:0] touch_way
);

    logic [WAY_BITS-1:0] age_q [NUM_SETS][NUM_WAYS];
    logic                found_invalid;

    // Ages stay a permutation of 0..NUM_WAYS-1; the oldest way holds NUM_WAYS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= WAY_BITS'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_BITS'(w) == touch_way) begin
                    age_q[touch_set][w] <= '0;
                end else if (age_q[touch_set][w] < age_q[touch_set][touch_way]) begin
                    age_q[touch_set][w] <= age_q[touch_set][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_way    = '0;
        found_invalid = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!found_invalid && !set_valid[w]) begin
                victim_way    = WAY_BITS'(w);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[lookup_set][w] == WAY_BITS'(NUM_WAYS - 1)) begin
                    victim_way = WAY_BITS'(w);
                end
            end
        end
    end

endmodule

// File: rtl/nway_cache.sv
// N-way set-associative write-back, write-allocate data cache with word-serial
// write-back/refill and true-LRU replacement.
module nway_cache
    import nway_cache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_WAYS       = 2,
    parameter int unsigned NUM_SETS       = 8,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input logic        clk,
    input logic        rst_n,
    nway_cache_if.slave bus
);

    localparam int unsigned BYTE_BITS = byte_off_bits(DATA_WIDTH);
    localparam int unsigned WORD_BITS = word_off_bits(WORDS_PER_LINE);
    localparam int unsigned BEAT_BITS = min1_clog2(WORDS_PER_LINE);
    localparam int unsigned SET_BITS  = set_bits(NUM_SETS);
    localparam int unsigned TAG_BITS  = tag_bits(ADDR_WIDTH, DATA_WIDTH, WORDS_PER_LINE, NUM_SETS);
    localparam int unsigned WAY_BITS  = min1_clog2(NUM_WAYS);
    localparam int unsigned SET_LSB   = BYTE_BITS + WORD_BITS;
    localparam int unsigned TAG_LSB   = SET_LSB + SET_BITS;
    localparam logic [BEAT_BITS-1:0] WORD_MASK = BEAT_BITS'(WORDS_PER_LINE - 1);

    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS][WORDS_PER_LINE];
    logic [TAG_BITS-1:0]   tag_q   [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];

    cache_state_e        state_q, state_d;
    logic [WAY_BITS-1:0] victim_q, victim_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;
    logic [SET_BITS-1:0] miss_set_q, miss_set_d;
    logic [TAG_BITS-1:0] miss_tag_q, miss_tag_d;

    logic [SET_BITS-1:0]  req_set;
    logic [TAG_BITS-1:0]  req_tag;
    logic [BEAT_BITS-1:0] req_word;
    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [WAY_BITS-1:0]  victim_way;
    logic                 touch_en, hit_write, wb_done, refill_we, refill_done;
    logic                 addr_unused;

    assign req_set     = bus.cpu_addr[SET_LSB +: SET_BITS];
    assign req_tag     = bus.cpu_addr[ADDR_WIDTH-1:TAG_LSB];
    assign req_word    = BEAT_BITS'(bus.cpu_addr >> BYTE_BITS) & WORD_MASK;
    assign addr_unused = ^(bus.cpu_addr & ADDR_WIDTH'((1 << BYTE_BITS) - 1));

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [TAG_BITS-1:0]  tag,
                                                        input logic [SET_BITS-1:0]  set,
                                                        input logic [BEAT_BITS-1:0] beat);
        return (ADDR_WIDTH'(tag) << TAG_LSB) | (ADDR_WIDTH'(set) << SET_LSB)
               | (ADDR_WIDTH'(beat & WORD_MASK) << BYTE_BITS);
    endfunction

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
            end
        end
    end

    lru_tracker #(
        .NUM_WAYS(NUM_WAYS),
        .NUM_SETS(NUM_SETS)
    ) u_lru (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_set(req_set),
        .set_valid (valid_q[req_set]),
        .victim_way(victim_way),
        .touch_en  (touch_en),
        .touch_set (req_set),
        .touch_way (hit_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOOKUP;
            victim_q   <= '0;
            beat_q     <= '0;
            miss_set_q <= '0;
            miss_tag_q <= '0;
        end else begin
            state_q    <= state_d;
            victim_q   <= victim_d;
            beat_q     <= beat_d;
            miss_set_q <= miss_set_d;
            miss_tag_q <= miss_tag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        beat_d        = beat_q;
        miss_set_d    = miss_set_q;
        miss_tag_d    = miss_tag_q;
        bus.cpu_ready = 1'b0;
        bus.cpu_rdata = '0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        touch_en      = 1'b0;
        hit_write     = 1'b0;
        wb_done       = 1'b0;
        refill_we     = 1'b0;
        refill_done   = 1'b0;
        unique case (state_q)
            LOOKUP: begin
                if (bus.cpu_req && hit) begin
                    bus.cpu_ready = 1'b1;
                    touch_en      = 1'b1;
                    if (bus.cpu_we) begin
                        hit_write = 1'b1;
                    end else begin
                        bus.cpu_rdata = data_q[req_set][hit_way][req_word];
                    end
                end else if (bus.cpu_req) begin
                    // Latch the miss so the fill completes even if the core drops its request.
                    victim_d   = victim_way;
                    beat_d     = '0;
                    miss_set_d = req_set;
                    miss_tag_d = req_tag;
                    state_d    = (valid_q[req_set][victim_way] && dirty_q[req_set][victim_way])
                                 ? WRITEBACK : REFILL;
                end
            end
            WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = beat_addr(tag_q[miss_set_q][victim_q], miss_set_q, beat_q);
                bus.mem_wdata = data_q[miss_set_q][victim_q][beat_q];
                if (bus.mem_ack) begin
                    if (beat_q == WORD_MASK) begin
                        beat_d  = '0;
                        wb_done = 1'b1;
                        state_d = REFILL;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = beat_addr(miss_tag_q, miss_set_q, beat_q);
                if (bus.mem_ack) begin
                    refill_we = 1'b1;
                    if (beat_q == WORD_MASK) begin
                        beat_d      = '0;
                        refill_done = 1'b1;
                        state_d     = LOOKUP;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            if (hit_write) dirty_q[req_set][hit_way] <= 1'b1;
            if (wb_done) dirty_q[miss_set_q][victim_q] <= 1'b0;
            if (refill_done) begin
                valid_q[miss_set_q][victim_q] <= 1'b1;
                dirty_q[miss_set_q][victim_q] <= 1'b0;
            end
        end
    end

    // Line payload needs no reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (hit_write) data_q[req_set][hit_way][req_word] <= bus.cpu_wdata;
        if (refill_we) data_q[miss_set_q][victim_q][beat_q] <= bus.mem_rdata;
        if (refill_done) tag_q[miss_set_q][victim_q] <= miss_tag_q;
    end

endmodule

// File: tb/tb_nway_cache.sv
// Randomised and directed checks of nway_cache against a recency-stamp line model.
module tb_nway_cache;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 32;
    localparam int unsigned WAYS = 2;
    localparam int unsigned SETS = 8;
    localparam int unsigned WPL  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nway_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    nway_cache_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus4 ();

    nway_cache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WAYS(WAYS), .NUM_SETS(SETS), .WORDS_PER_LINE(WPL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    nway_cache #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WAYS(4), .NUM_SETS(SETS), .WORDS_PER_LINE(WPL)
    ) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [31:0] env_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- memory responder for the 2-way DUT ----------------
    int    ack_wait = 0;   // negative: random 0..2 wait cycles per beat
    bit    pending = 1'b0;
    bit    waited;
    int    wait_left;
    beat_t cur;

    always @(negedge clk) begin
        bus.mem_ack = 1'b0;
        if (!rst_n || !bus.mem_req) begin
            pending = 1'b0;
        end else begin
            if (!pending) begin
                pending   = 1'b1;
                waited    = 1'b0;
                cur.we    = bus.mem_we;
                cur.addr  = bus.mem_addr;
                cur.wdata = bus.mem_wdata;
                wait_left = (ack_wait < 0) ? int'($urandom_range(2, 0)) : ack_wait;
            end
            if (wait_left == 0) begin
                if (waited) begin
                    check("mem_addr_stable", bus.mem_addr, cur.addr);
                    check("mem_wdata_stable", bus.mem_wdata, cur.wdata);
                    check("mem_we_stable", 32'(bus.mem_we), 32'(cur.we));
                end
                obs_q.push_back(cur);
                if (cur.we) env_mem[cur.addr] = cur.wdata;
                else bus.mem_rdata = env_mem.exists(cur.addr) ? env_mem[cur.addr]
                                                              : mem_init(cur.addr);
                bus.mem_ack = 1'b1;
                pending     = 1'b0;
            end else begin
                wait_left--;
                waited = 1'b1;
            end
        end
    end

    // ---------------- memory responder for the 4-way DUT ----------------
    logic [31:0] wb4_q[$];

    always @(negedge clk) begin
        bus4.mem_ack   = bus4.mem_req && rst_n;
        bus4.mem_rdata = bus4.mem_addr ^ 32'hA5A5_0000;
        if (bus4.mem_req && rst_n && bus4.mem_we) wb4_q.push_back(bus4.mem_addr);
    end

    // ---------------- reference model: lines with last-use timestamps ----------------
    logic [24:0] m_tag   [SETS][WAYS];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    logic [31:0] m_data  [SETS][WAYS][WPL];
    int unsigned m_used  [SETS][WAYS];
    int unsigned m_time = 0;

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_used[s][w]  = 0;
            end
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
    endfunction

    task automatic model_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                                output logic [31:0] rd, output bit hit);
        logic [2:0]  s  = addr[6:4];
        logic [24:0] t  = addr[31:7];
        logic [1:0]  wi = addr[3:2];
        int          way = -1;
        beat_t       e;
        for (int w = 0; w < WAYS; w++) begin
            if (m_valid[s][w] && m_tag[s][w] == t) way = w;
        end
        hit = (way >= 0);
        if (!hit) begin
            for (int w = 0; w < WAYS; w++) begin
                if (way < 0 && !m_valid[s][w]) way = w;
            end
            if (way < 0) begin
                way = 0;
                for (int w = 1; w < WAYS; w++) begin
                    if (m_used[s][w] < m_used[s][way]) way = w;
                end
            end
            if (m_valid[s][way] && m_dirty[s][way]) begin
                for (int b = 0; b < WPL; b++) begin
                    e.we    = 1'b1;
                    e.addr  = {m_tag[s][way], s, 2'(b), 2'b00};
                    e.wdata = m_data[s][way][b];
                    exp_q.push_back(e);
                    ref_mem[e.addr] = e.wdata;
                end
            end
            for (int b = 0; b < WPL; b++) begin
                e.we    = 1'b0;
                e.addr  = {t, s, 2'(b), 2'b00};
                e.wdata = '0;
                exp_q.push_back(e);
                m_data[s][way][b] = ref_read(e.addr);
            end
            m_tag[s][way]   = t;
            m_valid[s][way] = 1'b1;
            m_dirty[s][way] = 1'b0;
        end
        m_time++;
        m_used[s][way] = m_time;
        rd = m_data[s][way][wi];
        if (we) begin
            m_data[s][way][wi] = wdata;
            m_dirty[s][way]    = 1'b1;
        end
    endtask

    // ---------------- CPU drivers (called just after a rising edge) ----------------
    task automatic cpu_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              output int cycles, output logic [31:0] rdata, output bit done);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        cycles = 0;
        done   = 1'b0;
        rdata  = '0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus.cpu_ready) begin
                done  = 1'b1;
                rdata = bus.cpu_rdata;
            end
            @(posedge clk);
            #1;
        end
        bus.cpu_req = 1'b0;
    endtask

    task automatic compare_beats();
        check("beat_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            check("beat_we", 32'(obs_q[i].we), 32'(exp_q[i].we));
            check("beat_addr", obs_q[i].addr, exp_q[i].addr);
            if (exp_q[i].we) check("beat_wdata", obs_q[i].wdata, exp_q[i].wdata);
        end
    endtask

    task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input int exp_lat);
        logic [31:0] exp_rd, rd;
        bit          hit, done;
        int          cyc;
        obs_q.delete();
        exp_q.delete();
        model_access(addr, we, wdata, exp_rd, hit);
        cpu_access(addr, we, wdata, cyc, rd, done);
        check("ready_timeout", 32'(done), 32'd1);
        if (!we) check("rdata", rd, exp_rd);
        if (hit) check("hit_latency", 32'(cyc), 32'd1);
        if (exp_lat >= 0) check("miss_latency", 32'(cyc), 32'(exp_lat));
        compare_beats();
    endtask

    task automatic acc4(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                        output logic [31:0] rdata);
        int cycles = 0;
        bit done   = 1'b0;
        bus4.cpu_req   = 1'b1;
        bus4.cpu_we    = we;
        bus4.cpu_addr  = addr;
        bus4.cpu_wdata = wdata;
        rdata = '0;
        while (!done && cycles < 200) begin
            @(negedge clk);
            cycles++;
            if (bus4.cpu_ready) begin
                done  = 1'b1;
                rdata = bus4.cpu_rdata;
            end
            @(posedge clk);
            #1;
        end
        bus4.cpu_req = 1'b0;
        check("acc4_timeout", 32'(done), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd4, first_wb;
        int          guard;
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus4.cpu_req   = 1'b0;
        bus4.cpu_we    = 1'b0;
        bus4.cpu_addr  = '0;
        bus4.cpu_wdata = '0;
        model_reset();

        repeat (3) @(negedge clk);
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Cold read, then hits on the filled line.
        ack_wait = 0;
        run_access(32'h040, 1'b0, '0, 6);
        check("cold_rdata_beats", 32'(obs_q.size()), 32'd4);
        run_access(32'h044, 1'b0, '0, 1);
        run_access(32'h044, 1'b1, 32'hDEAD_BEEF, 1);
        run_access(32'h044, 1'b0, '0, 1);

        // Set 4 conflicts: clean eviction of 0x0C0, then dirty eviction of 0x040.
        run_access(32'h040, 1'b1, 32'h1234_5678, 1);
        run_access(32'h0C0, 1'b0, '0, 6);
        run_access(32'h040, 1'b0, '0, 1);
        run_access(32'h140, 1'b0, '0, 6);
        run_access(32'h0C0, 1'b0, '0, 10);
        check("wb_first_addr", (obs_q.size() > 1) ? obs_q[0].addr : 32'hFFFF_FFFF, 32'h40);
        check("wb_word1_data", (obs_q.size() > 1) ? obs_q[1].wdata : 32'hFFFF_FFFF,
              32'hDEAD_BEEF);

        // Slow memory: three wait cycles per beat.
        ack_wait = 3;
        run_access(32'h200, 1'b0, '0, 18);

        // Reset in the middle of refill beat 2.
        ack_wait = 1;
        obs_q.delete();
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h7F0;
        guard = 0;
        while (obs_q.size() < 2 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("refill_progress", 32'(obs_q.size()), 32'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mem_req_on_reset", 32'(bus.mem_req), 32'd0);
        check("cpu_ready_on_reset", 32'(bus.cpu_ready), 32'd0);
        bus.cpu_req = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ack_wait = 0;
        run_access(32'h7F0, 1'b0, '0, 6);

        // Random traffic over a few tags per set to force conflicts.
        ack_wait = -1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = {25'($urandom_range(5, 0)), 3'($urandom), 2'($urandom), 2'b00};
            run_access(a, 1'($urandom), $urandom, -1);
            repeat ($urandom_range(1, 0)) begin
                @(posedge clk);
                #1;
            end
        end

        // 4-way LRU: fill A..D dirty, touch A, then E evicts B and F evicts C.
        acc4(32'h080, 1'b1, 32'h0000_0011, rd4);
        acc4(32'h100, 1'b1, 32'h0000_0022, rd4);
        acc4(32'h180, 1'b1, 32'h0000_0033, rd4);
        acc4(32'h200, 1'b1, 32'h0000_0044, rd4);
        acc4(32'h080, 1'b0, '0, rd4);
        check("lru4_read_a", rd4, 32'h0000_0011);
        wb4_q.delete();
        acc4(32'h280, 1'b1, 32'h0000_0055, rd4);
        first_wb = (wb4_q.size() > 0) ? wb4_q[0] : 32'hFFFF_FFFF;
        check("lru4_wb_count_e", 32'(wb4_q.size()), 32'd4);
        check("lru4_victim_e", first_wb, 32'h100);
        wb4_q.delete();
        acc4(32'h300, 1'b1, 32'h0000_0066, rd4);
        first_wb = (wb4_q.size() > 0) ? wb4_q[0] : 32'hFFFF_FFFF;
        check("lru4_victim_f", first_wb, 32'h180);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
